// File: rtl/axis_rate_limit_if.sv
// AXI-Stream bundle used on both sides of the rate limiter.
// master drives payload/valid and samples ready; slave does the reverse.
interface axis_rate_limit_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axis_rate_limit.sv
// AXI-Stream rate limiter: a credit accumulator throttles accepted words to an
// average of rate_num/rate_denom words per cycle, either per word or per frame
// start. The output is registered behind a one-entry skid buffer, so
// input_axis.tready never depends combinationally on output_axis.tready.
module axis_rate_limit #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    axis_rate_limit_if.slave         input_axis,
    axis_rate_limit_if.master        output_axis,

    input  logic [7:0]               rate_num,
    input  logic [7:0]               rate_denom,
    input  logic                     rate_by_frame
);

    localparam int unsigned AccWidth  = 24;
    localparam int unsigned WordWidth = DATA_WIDTH + 2;
    localparam logic [AccWidth-1:0] AccMax = '1;

    // Credit accumulator and frame tracking
    logic [AccWidth-1:0]  acc_q;
    logic [AccWidth-1:0]  acc_d;
    logic [AccWidth-1:0]  acc_base;
    logic [AccWidth:0]    acc_sum;
    logic [AccWidth-1:0]  num_ext;
    logic [AccWidth-1:0]  den_ext;
    logic                 in_frame_q;
    logic                 in_frame_d;

    logic                 throttle_off;
    logic                 credit_ok;
    logic                 allow;
    logic                 ready_int;
    logic                 accept;

    // Output register and skid register, each {tlast, tuser, tdata}
    logic [WordWidth-1:0] in_word;
    logic [WordWidth-1:0] out_word_q;
    logic [WordWidth-1:0] out_word_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [WordWidth-1:0] temp_word_q;
    logic [WordWidth-1:0] temp_word_d;
    logic                 temp_valid_q;
    logic                 temp_valid_d;

    assign num_ext = {{(AccWidth - 8){1'b0}}, rate_num};
    assign den_ext = {{(AccWidth - 8){1'b0}}, rate_denom};
    assign in_word = {input_axis.tlast, input_axis.tuser, input_axis.tdata};

    // Admission decision from registered state and the live rate inputs
    always_comb begin
        throttle_off = (rate_num == 8'd0) || (rate_num >= rate_denom);
        credit_ok    = (acc_q <= num_ext);
        if (throttle_off) begin
            allow = 1'b1;
        end else if (rate_by_frame) begin
            // Once a frame has started it runs to tlast at full rate.
            allow = in_frame_q | credit_ok;
        end else begin
            allow = credit_ok;
        end
        ready_int = ~rst & ~temp_valid_q & allow;
        accept    = input_axis.tvalid & ready_int;
    end

    assign input_axis.tready = ready_int;

    // Accumulator next state: refund rate_num each cycle, charge rate_denom per accept
    always_comb begin
        acc_base = (acc_q > num_ext) ? (acc_q - num_ext) : '0;
        acc_sum  = {1'b0, acc_base} + {1'b0, den_ext};
        if (throttle_off) begin
            acc_d = '0;
        end else if (accept) begin
            // Saturate so a very long frame cannot wrap into a small debt.
            acc_d = acc_sum[AccWidth] ? AccMax : acc_sum[AccWidth-1:0];
        end else begin
            acc_d = acc_base;
        end

        in_frame_d = in_frame_q;
        if (accept) begin
            in_frame_d = ~input_axis.tlast;
        end
    end

    // Output/skid register next state
    always_comb begin
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        temp_valid_d = temp_valid_q;
        temp_word_d  = temp_word_q;
        if (accept) begin
            // accept implies temp is empty, so the word goes to out unless out is stuck.
            if (!out_valid_q || output_axis.tready) begin
                out_valid_d = 1'b1;
                out_word_d  = in_word;
            end else begin
                temp_valid_d = 1'b1;
                temp_word_d  = in_word;
            end
        end else if (output_axis.tready) begin
            if (temp_valid_q) begin
                out_word_d   = temp_word_q;
                temp_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            in_frame_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            temp_valid_q <= 1'b0;
            temp_word_q  <= '0;
        end else begin
            acc_q        <= acc_d;
            in_frame_q   <= in_frame_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            temp_valid_q <= temp_valid_d;
            temp_word_q  <= temp_word_d;
        end
    end

    assign output_axis.tvalid = out_valid_q;
    assign output_axis.tlast  = out_word_q[WordWidth-1];
    assign output_axis.tuser  = out_word_q[WordWidth-2];
    assign output_axis.tdata  = out_word_q[DATA_WIDTH-1:0];

    // The skid slot can only be occupied behind a full output register.
    skid_behind_out: assert property (@(posedge clk) disable iff (rst)
        temp_valid_q |-> out_valid_q);

    // Never take a word while the skid slot is already holding one.
    no_accept_when_full: assert property (@(posedge clk) disable iff (rst)
        temp_valid_q |-> !input_axis.tready);

endmodule

// File: tb/tb_axis_rate_limit.sv
// Self-checking bench for axis_rate_limit: table-driven vectors, directed
// corner-case sequences and randomized traffic against a queue/arithmetic model.
module tb_axis_rate_limit;

    localparam int unsigned AccMaxInt = 32'h00FF_FFFF;

    logic clk;
    logic rst;
    logic [7:0] rate_num;
    logic [7:0] rate_denom;
    logic rate_by_frame;

    axis_rate_limit_if #(.DATA_WIDTH(8)) in_if ();
    axis_rate_limit_if #(.DATA_WIDTH(8)) out_if ();

    axis_rate_limit #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .input_axis    (in_if),
        .output_axis   (out_if),
        .rate_num      (rate_num),
        .rate_denom    (rate_denom),
        .rate_by_frame (rate_by_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Driven values for the next cycle
    logic       d_valid, d_last, d_user, d_oready, d_frame, d_rst;
    logic [7:0] d_data, d_num, d_den;

    // Reference model: words held in the DUT, credit, frame state
    logic [9:0]  m_q[$];
    int unsigned m_acc;
    logic        m_in_frame;
    logic        m_last_accept;

    // Observations of the most recent cycle
    logic        obs_ready, obs_valid;
    logic [9:0]  obs_word;
    int unsigned obs_acc;

    typedef struct {
        logic        v;
        logic        l;
        logic        oready;
        logic [7:0]  num;
        logic [7:0]  den;
        logic        frame;
        logic        exp_ready;
        int unsigned exp_acc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance the model.
    task automatic step();
        logic thr_off, allow, exp_ready, acc_now, emit;
        int unsigned base;
        @(negedge clk);
        in_if.tvalid  = d_valid;
        in_if.tdata   = d_data;
        in_if.tlast   = d_last;
        in_if.tuser   = d_user;
        out_if.tready = d_oready;
        rate_num      = d_num;
        rate_denom    = d_den;
        rate_by_frame = d_frame;
        rst           = d_rst;
        #1;
        thr_off   = (d_num == 0) || (d_num >= d_den);
        allow     = thr_off || (m_acc <= d_num) || (d_frame && m_in_frame);
        exp_ready = !d_rst && (m_q.size() < 2) && allow;

        obs_ready = in_if.tready;
        obs_valid = out_if.tvalid;
        obs_word  = {out_if.tlast, out_if.tuser, out_if.tdata};
        obs_acc   = 32'(dut.acc_q);

        check("tready", 32'(obs_ready), 32'(exp_ready));
        check("tvalid", 32'(obs_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("out_word", 32'(obs_word), 32'(m_q[0]));
        check("acc", obs_acc, m_acc);

        acc_now = exp_ready && d_valid;
        emit    = (m_q.size() > 0) && d_oready;
        if (d_rst) begin
            m_q.delete();
            m_acc      = 0;
            m_in_frame = 1'b0;
        end else begin
            if (emit) void'(m_q.pop_front());
            if (acc_now) m_q.push_back({d_last, d_user, d_data});
            base = (m_acc > d_num) ? m_acc - d_num : 0;
            if (thr_off) m_acc = 0;
            else if (acc_now) m_acc = (base + d_den > AccMaxInt) ? AccMaxInt : base + d_den;
            else m_acc = base;
            if (acc_now) m_in_frame = !d_last;
        end
        m_last_accept = acc_now;
    endtask

    task automatic do_reset();
        d_rst = 1'b1;
        d_valid = 1'b0;
        step();
        step();
        d_rst = 1'b0;
        step();
        check("reset_tvalid", 32'(obs_valid), 32'd0);
        check("reset_word", 32'(obs_word), 32'd0);
        check("reset_acc", obs_acc, 32'd0);
    endtask

    function automatic void add_vec(logic v, logic l, logic oready, logic [7:0] num,
                                    logic [7:0] den, logic frame, logic er, int unsigned ea);
        vec_t r;
        r.v = v; r.l = l; r.oready = oready; r.num = num; r.den = den; r.frame = frame;
        r.exp_ready = er; r.exp_acc = ea;
        vecs.push_back(r);
    endfunction

    initial begin
        int accepts;
        int stall_acc;
        logic [9:0] prev;
        logic stall_ready_exp[5];
        int frame_ready_exp[9];
        int frame_acc_exp[9];

        m_acc = 0; m_in_frame = 1'b0; m_last_accept = 1'b0;
        d_valid = 0; d_last = 0; d_user = 0; d_oready = 1; d_frame = 0; d_rst = 1;
        d_data = 0; d_num = 0; d_den = 0;
        in_if.tvalid = 0; in_if.tdata = 0; in_if.tlast = 0; in_if.tuser = 0;
        out_if.tready = 1; rate_num = 0; rate_denom = 0; rate_by_frame = 0; rst = 1;

        // Word mode 1/4: accepts every 4th cycle, acc 0,4,3,2,1,4,...
        for (int k = 0; k < 29; k++) begin
            int unsigned ea;
            case (k % 4)
                0: ea = (k == 0) ? 0 : 1;
                1: ea = 4;
                2: ea = 3;
                default: ea = 2;
            endcase
            add_vec(1'b1, 1'b0, 1'b1, 8'd1, 8'd4, 1'b0, (k % 4) == 0, ea);
        end
        // Frame mode 1/2: frame 1 on cycles 0-3, frame 2 starts on cycle 8
        frame_ready_exp = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        frame_acc_exp   = '{0, 2, 3, 4, 5, 4, 3, 2, 1};
        for (int k = 0; k < 9; k++) begin
            add_vec(1'b1, k == 3, 1'b1, 8'd1, 8'd2, 1'b1, frame_ready_exp[k] != 0,
                    frame_acc_exp[k]);
        end

        do_reset();
        accepts = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 29) do_reset();
            d_valid = vecs[i].v; d_last = vecs[i].l; d_user = 1'(i % 3 == 0);
            d_data = 8'(i); d_oready = vecs[i].oready; d_num = vecs[i].num;
            d_den = vecs[i].den; d_frame = vecs[i].frame;
            step();
            check("vec_ready", 32'(obs_ready), 32'(vecs[i].exp_ready));
            check("vec_acc", obs_acc, vecs[i].exp_acc);
            if (i < 29 && obs_ready && d_valid) accepts++;
            if (i == 28) check("word_mode_8_in_29", 32'(accepts), 32'd8);
        end

        // Throttle off (0/5 then 3/3): one word per cycle, output = input delayed by one
        do_reset();
        d_oready = 1; d_valid = 1; d_frame = 0;
        prev = '0;
        for (int k = 0; k < 16; k++) begin
            d_num = (k < 8) ? 8'd0 : 8'd3;
            d_den = (k < 8) ? 8'd5 : 8'd3;
            d_data = 8'($urandom); d_last = 1'($urandom); d_user = 1'($urandom);
            step();
            check("thr_off_ready", 32'(obs_ready), 32'd1);
            if (k > 0) check("thr_off_delay", 32'(obs_word), 32'(prev));
            prev = {d_last, d_user, d_data};
        end

        // Backpressure: stall starting with an empty pipeline, two words absorbed
        do_reset();
        d_num = 0; d_den = 1; d_frame = 0; d_last = 0; d_user = 0; d_data = 8'h40;
        for (int k = 0; k < 3; k++) begin
            d_valid = 1; d_oready = 1;
            step();
            if (m_last_accept) d_data++;
        end
        d_valid = 0;
        step();
        stall_ready_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        stall_acc = 0;
        for (int k = 0; k < 5; k++) begin
            d_valid = 1; d_oready = 0;
            step();
            check("stall_ready", 32'(obs_ready), 32'(stall_ready_exp[k]));
            if (m_last_accept) begin
                stall_acc++;
                d_data++;
            end
        end
        check("stall_accepts", 32'(stall_acc), 32'd2);
        for (int k = 0; k < 6; k++) begin
            d_valid = (k < 2); d_oready = 1;
            step();
            if (m_last_accept) d_data++;
        end
        check("drained", 32'(obs_valid), 32'd0);

        // Reset mid-frame with output stalled
        do_reset();
        d_num = 1; d_den = 4; d_frame = 1; d_oready = 0; d_valid = 1; d_user = 0;
        for (int k = 0; k < 2; k++) begin
            d_data = 8'(8'h80 + k); d_last = 0;
            step();
            check("mid_frame_accept", 32'(obs_ready), 32'd1);
        end
        d_rst = 1;
        step();
        check("rst_ready_low", 32'(obs_ready), 32'd0);
        d_rst = 0; d_oready = 1;
        for (int k = 0; k < 4; k++) begin
            d_data = 8'(8'hA0 + k); d_last = (k == 3);
            step();
            if (k == 0) begin
                check("post_rst_tvalid", 32'(obs_valid), 32'd0);
                check("post_rst_acc", obs_acc, 32'd0);
            end
            check("post_rst_frame_ready", 32'(obs_ready), 32'd1);
        end

        // Live rate change 1/4 -> 1/1 while acc = 3
        do_reset();
        d_num = 1; d_den = 4; d_frame = 0; d_valid = 1; d_oready = 1; d_last = 0;
        step();
        step();
        d_num = 1; d_den = 1;
        step();
        check("live_acc_before", obs_acc, 32'd3);
        check("live_ready", 32'(obs_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("live_acc_zero", obs_acc, 32'd0);
            check("live_full_rate", 32'(obs_ready), 32'd1);
        end

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) begin
                d_num = 8'($urandom_range(0, 5));
                d_den = 8'($urandom_range(0, 8));
                d_frame = 1'($urandom);
            end
            d_valid = ($urandom % 4) != 0;
            d_oready = ($urandom % 4) != 0;
            d_data = 8'($urandom); d_last = ($urandom % 4) == 0; d_user = 1'($urandom);
            d_rst = ($urandom % 200) == 0;
            step();
        end
        d_rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
